// File: rtl/booth_mult_seq_if.sv
// Start/operand and result handshake of the sequential Booth multiplier.
// master = requester (multdiv control), slave = booth_mult_seq.
interface booth_mult_seq_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier (32x32 signed -> low 32 bits + overflow)
// built around the shared 32-bit carry-lookahead add/subtract unit addCalc.
module addCalc (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        subTrue,
  output logic [31:0] S,
  output logic        overflow,
  output logic        isNotEqual,
  output logic        isLessThan
);
  logic [31:0] bx;
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  bc;

  // Two-level lookahead: 4-bit group generate/propagate, then group carries.
  always_comb begin
    bx = B ^ {32{subTrue}};
    g  = A & bx;
    p  = A ^ bx;
    gg = '0;
    gp = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    bc    = '0;
    bc[0] = subTrue;
    for (int unsigned k = 0; k < 8; k++) begin
      bc[k+1] = gg[k] | (gp[k] & bc[k]);
    end
    c = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      c[4*k]   = bc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
    end
    c[32]      = bc[8];
    S          = p ^ c[31:0];
    overflow   = c[32] ^ c[31];
    isNotEqual = |S;
    isLessThan = S[31] ^ overflow;
  end
endmodule

module booth_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic              clock,
  input  logic              reset,
  booth_mult_seq_if.slave   bus
);
  generate
    if (WIDTH != 32) begin : g_bad_width
      $error("booth_mult_seq: WIDTH must be 32 (adder is fixed-width)");
    end
    if (ITER != WIDTH) begin : g_bad_iter
      $error("booth_mult_seq: ITER must equal WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   ph_q, ph_d;
  logic [WIDTH-1:0]   pl_q, pl_d;
  logic               q_q, q_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic               add_sub;
  logic               add_take;
  logic [WIDTH-1:0]   add_s;
  logic               add_ovf;
  logic               add_ne_unused;
  logic               add_lt_unused;
  logic [WIDTH-1:0]   t_val;
  logic               t_sgn;
  logic [WIDTH-1:0]   ph_shift;
  logic [WIDTH-1:0]   pl_shift;

  addCalc u_add (
    .A          (ph_q),
    .B          (m_q),
    .subTrue    (add_sub),
    .S          (add_s),
    .overflow   (add_ovf),
    .isNotEqual (add_ne_unused),
    .isLessThan (add_lt_unused)
  );

  // Sign comes from S xor overflow so PH-M with M = -2^31 still shifts in the true sign.
  always_comb begin
    add_sub  = (pl_q[0] == 1'b1) && (q_q == 1'b0);
    add_take = pl_q[0] ^ q_q;
    t_val    = add_take ? add_s : ph_q;
    t_sgn    = add_take ? (add_s[WIDTH-1] ^ add_ovf) : ph_q[WIDTH-1];
    ph_shift = {t_sgn, t_val[WIDTH-1:1]};
    pl_shift = {t_val[0], pl_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    ph_d     = ph_q;
    pl_d     = pl_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
    if (bus.ctrl_MULT) begin
      m_d     = bus.data_operandA;
      pl_d    = bus.data_operandB;
      ph_d    = '0;
      q_d     = 1'b0;
      cnt_d   = '0;
      state_d = RUN;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          ph_d  = ph_shift;
          pl_d  = pl_shift;
          q_d   = pl_q[0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(ITER - 1)) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            rdy_d    = 1'b1;
            result_d = pl_shift;
            exc_d    = (ph_shift != {WIDTH{pl_shift[WIDTH-1]}});
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      ph_q     <= '0;
      pl_q     <= '0;
      q_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      ph_q     <= ph_d;
      pl_q     <= pl_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a cycle-level product model checked every
// cycle, plus literal expectations for the listed operand pairs.
module tb_booth_mult_seq;
  logic clock;
  logic reset;
  booth_mult_seq_if bif ();

  booth_mult_seq #(.WIDTH(32), .ITER(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: 32 cycles after a start, the signed 64-bit product is truncated.
  logic        m_busy = 1'b0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_res = '0;
  logic        m_exc = 1'b0;
  int          m_left = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  always @(posedge clock) begin
    longint sa, sb, prod, low_sext;
    if (reset) begin
      m_busy = 1'b0; m_rdy = 1'b0; m_res = '0; m_exc = 1'b0; m_left = 0;
    end else if (bif.ctrl_MULT) begin
      m_busy = 1'b1; m_rdy = 1'b0; m_left = 32;
      m_a = bif.data_operandA; m_b = bif.data_operandB;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        prod = sa * sb;
        m_res = prod[31:0];
        low_sext = longint'($signed(m_res));
        m_exc = (prod != low_sext);
        m_busy = 1'b0;
        m_rdy = 1'b1;
      end
    end else begin
      m_rdy = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy",  {31'd0, bif.busy},           {31'd0, m_busy});
      chk("rdy",   {31'd0, bif.data_resultRDY}, {31'd0, m_rdy});
      chk("result", bif.data_result,            m_res);
      chk("exc",   {31'd0, bif.data_exception}, {31'd0, m_exc});
    end
  end

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bif.ctrl_MULT = 1'b1;
    bif.data_operandA = a;
    bif.data_operandB = b;
    @(negedge clock);
    bif.ctrl_MULT = 1'b0;
  endtask

  // Waits (bounded) for RDY after a start and checks latency and literal results.
  task automatic wait_check(input string name, input logic [31:0] er, input logic ee);
    int cyc = 1;
    while (!bif.data_resultRDY && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'd33);
    chk({name, "_res"}, bif.data_result, er);
    chk({name, "_exc"}, {31'd0, bif.data_exception}, {31'd0, ee});
    chk({name, "_model"}, m_res, er);
    @(negedge clock);
  endtask

  task automatic mult(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ee);
    pulse_start(a, b);
    wait_check(name, er, ee);
  endtask

  initial begin
    reset = 1'b1;
    bif.ctrl_MULT = 1'b0;
    bif.data_operandA = '0;
    bif.data_operandB = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    chk("rst_result", bif.data_result, 32'h0);
    chk("rst_busy", {31'd0, bif.busy}, 32'd0);
    chk("rst_rdy", {31'd0, bif.data_resultRDY}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    mult("m7x-3",     32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    mult("mmin_x-1",  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    mult("mmin_x1",   32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    mult("mmin_xmin", 32'h8000_0000,  32'h8000_0000, 32'h0,         1'b1);
    mult("m2p16sq",   32'h0001_0000,  32'h0001_0000, 32'h0,         1'b1);
    mult("mffffsq",   32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
    mult("m46341",    32'd46341,      32'd46340,     32'd2147441940, 1'b0);
    mult("m-5x-6",    32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'd30,        1'b0);

    // Back-to-back: restart in the DONE cycle.
    pulse_start(32'd9, 32'd9);
    begin
      int cyc = 1;
      while (!bif.data_resultRDY && cyc < 40) begin
        @(negedge clock);
        cyc++;
      end
      chk("b2b_first", bif.data_result, 32'd81);
      bif.ctrl_MULT = 1'b1;
      bif.data_operandA = 32'hFFFF_FFFF;
      bif.data_operandB = 32'd100;
      @(negedge clock);
      bif.ctrl_MULT = 1'b0;
      chk("b2b_rdy_drop", {31'd0, bif.data_resultRDY}, 32'd0);
      wait_check("b2b_second", 32'hFFFF_FF9C, 1'b0);
    end

    // Abort mid-run and restart with new operands.
    pulse_start(32'd5, 32'd5);
    repeat (9) @(negedge clock);
    mult("abort_3x4", 32'd3, 32'd4, 32'd12, 1'b0);

    // Reset mid-run, with a start held alongside it.
    pulse_start(32'd123, 32'd456);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    bif.ctrl_MULT = 1'b1;
    bif.data_operandA = 32'd2;
    bif.data_operandB = 32'd3;
    @(negedge clock);
    chk("rst_mid_result", bif.data_result, 32'h0);
    chk("rst_mid_busy", {31'd0, bif.busy}, 32'd0);
    @(negedge clock);
    chk("rst_hold_busy", {31'd0, bif.busy}, 32'd0);
    reset = 1'b0;
    bif.ctrl_MULT = 1'b0;
    repeat (40) @(negedge clock);
    chk("post_rst_rdy", {31'd0, bif.data_resultRDY}, 32'd0);
    chk("post_rst_busy", {31'd0, bif.busy}, 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
